// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive blocks.
//   uart_state_t   - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   COUNT_REG_LEN  - width of the per-bit cycle counter
//   cycles_per_bit - clock cycles per line bit for a given bit rate and clock
`timescale 1ns/1ps
package uart_pkg;

  localparam int COUNT_REG_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Bit period and clock period are computed in ns, so both sides of a
  // loopback agree on the same truncated cycle count.
  function automatic int cycles_per_bit(input int bit_rate, input int clk_mhz);
    int bit_p;
    int clk_p;
    bit_p = 1_000_000_000 / bit_rate;
    clk_p = 1000 / clk_mhz;
    return bit_p / clk_p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for a single asynchronous input.
//   clk      - destination clock
//   resetn   - asynchronous active-low reset; both flops reset to 1
//   async_bit - asynchronous input
//   sync_bit  - input resynchronised to clk (two cycles of latency)
`timescale 1ns/1ps
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic async_bit,
  output logic sync_bit
);

  logic meta;

  // Reset to 1 so an idle-high serial line never looks like a start bit
  // while the synchroniser is coming out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta     <= 1'b1;
      sync_bit <= 1'b1;
    end else begin
      meta     <= async_bit;
      sync_bit <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start bit, PAYLOAD_BITS data bits LSB first,
// STOP_BITS stop bits.
//   clk               - system clock
//   resetn            - asynchronous active-low reset
//   uart_rxd          - serial line, idle high, asynchronous to clk
//   uart_rx_en        - receive enable, only gates the start of a new frame
//   uart_rx_busy      - high while a frame is being received
//   uart_rx_valid     - one-cycle pulse when a frame completes
//   uart_rx_data      - last received word, held until the next valid
//   uart_rx_frame_err - with uart_rx_valid: a stop-bit sample was 0
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_MHZ      = 50,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err
);

  localparam int CPB = cycles_per_bit(BIT_RATE, CLK_MHZ);
  localparam logic [COUNT_REG_LEN-1:0] CPB_C  = COUNT_REG_LEN'(CPB);
  localparam logic [COUNT_REG_LEN-1:0] HALF_C = COUNT_REG_LEN'(CPB / 2);
  localparam logic [3:0] LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic                     rxd_s;
  uart_state_t              state;
  logic [COUNT_REG_LEN-1:0] count;
  logic [3:0]               bit_cnt;
  logic [PAYLOAD_BITS-1:0]  shift;
  logic [PAYLOAD_BITS-1:0]  shift_next;
  logic                     stop_err;
  logic                     seen_high;

  uart_rx_sync u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_bit(uart_rxd),
    .sync_bit (rxd_s)
  );

  // New samples enter at the MSB so that after PAYLOAD_BITS shifts the
  // first (LSB-first) bit on the line ends up in bit 0.
  always_comb begin
    shift_next = shift >> 1;
    shift_next[PAYLOAD_BITS-1] = rxd_s;
  end

  // Receive FSM. Start is qualified at half a bit, then every bit is sampled
  // one bit period later, which lands near the middle of each bit. seen_high
  // stops a line held low (break) from being received as endless frames.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      count             <= '0;
      bit_cnt           <= '0;
      shift             <= '0;
      stop_err          <= 1'b0;
      seen_high         <= 1'b0;
      uart_rx_busy      <= 1'b0;
      uart_rx_valid     <= 1'b0;
      uart_rx_data      <= '0;
      uart_rx_frame_err <= 1'b0;
    end else begin
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rxd_s) begin
            seen_high <= 1'b1;
          end
          if (uart_rx_en && !rxd_s && seen_high) begin
            state        <= START;
            uart_rx_busy <= 1'b1;
            count        <= '0;
            bit_cnt      <= '0;
            stop_err     <= 1'b0;
            seen_high    <= 1'b0;
          end
        end
        START: begin
          if (count == HALF_C) begin
            count <= '0;
            if (rxd_s) begin
              state        <= IDLE;
              uart_rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            count <= count + COUNT_REG_LEN'(1);
          end
        end
        DATA: begin
          if (count == CPB_C) begin
            count <= '0;
            shift <= shift_next;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            count <= count + COUNT_REG_LEN'(1);
          end
        end
        STOP: begin
          if (count == CPB_C) begin
            count <= '0;
            if (!rxd_s) begin
              stop_err <= 1'b1;
            end
            if (bit_cnt == LAST_STOP) begin
              state             <= IDLE;
              uart_rx_busy      <= 1'b0;
              uart_rx_valid     <= 1'b1;
              uart_rx_data      <= shift;
              uart_rx_frame_err <= stop_err | ~rxd_s;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            count <= count + COUNT_REG_LEN'(1);
          end
        end
        default: begin
          state        <= IDLE;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 50 MHz / 1 Mbit/s (50 cycles
// per bit). Frames are generated bit by bit; the expected word and error flag
// of each frame that should be received are queued when it is sent, and a
// monitor compares them whenever uart_rx_valid pulses.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int P = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rxd;
  logic         en;
  logic         busy;
  logic         valid;
  logic [P-1:0] data;
  logic         err;

  typedef struct {
    logic [P-1:0] data;
    logic         err;
    int           start_cyc;
    int           bit_len;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_count = 0;
  int   lat;
  bit   busy_seen = 1'b0;
  bit   prev_valid = 1'b0;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .BIT_RATE    (1_000_000),
    .CLK_MHZ     (50),
    .PAYLOAD_BITS(P),
    .STOP_BITS   (1)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .uart_rxd         (rxd),
    .uart_rx_en       (en),
    .uart_rx_busy     (busy),
    .uart_rx_valid    (valid),
    .uart_rx_data     (data),
    .uart_rx_frame_err(err)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued frame and must
  // land inside that frame's stop bit on the line.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen = 1'b1;
    if (valid === 1'b1) begin
      valid_count++;
      check_output("valid_one_cycle", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got data 0x%0h, expected no frame", data);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - e.start_cyc;
        check_output("rx_data", 32'(data), 32'(e.data));
        check_output("rx_frame_err", 32'(err), 32'(e.err));
        check_output("valid_in_stop_bit",
                     32'(lat >= (1 + P) * e.bit_len && lat <= (2 + P) * e.bit_len + 4), 32'd1);
      end
    end
    prev_valid = (valid === 1'b1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    wait_cycles(n);
  endtask

  // Sends one frame; queues its expected result only if it should be received.
  task automatic apply_stimulus(input logic [P-1:0] d, input int bit_len,
                                input logic stop_val, input bit expect_it);
    exp_t x;
    if (expect_it) begin
      x.data      = d;
      x.err       = ~stop_val;
      x.start_cyc = cyc;
      x.bit_len   = bit_len;
      exp_q.push_back(x);
    end
    drive_bit(1'b0, bit_len);
    for (int i = 0; i < P; i++) drive_bit(d[i], bit_len);
    drive_bit(stop_val, bit_len);
    rxd = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_cycles(1);
    check_output(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vc;
    int t0;
    int gap;
    logic [P-1:0] d;
    bit ok;

    resetn = 1'b0;
    rxd    = 1'b1;
    en     = 1'b1;
    #25;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_valid", 32'(valid), 32'd0);
    check_output("reset_data", 32'(data), 32'd0);
    check_output("reset_frame_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_cycles(5);

    // Basic frame, nominal bit length.
    vc = valid_count;
    apply_stimulus(8'hA5, 50, 1'b1, 1'b1);
    wait_cycles(10);
    drain("drain_a5");
    check_output("a5_valid_count", 32'(valid_count - vc), 32'd1);

    // Asynchronous reset between clock edges clears the held word.
    #5;
    resetn = 1'b0;
    #2;
    check_output("async_reset_data", 32'(data), 32'd0);
    check_output("async_reset_busy", 32'(busy), 32'd0);
    check_output("async_reset_valid", 32'(valid), 32'd0);
    check_output("async_reset_frame_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_cycles(5);

    // Short glitch: START is entered then abandoned at the half-bit check.
    vc = valid_count;
    busy_seen = 1'b0;
    t0 = cyc;
    drive_bit(1'b0, 10);
    rxd = 1'b1;
    wait_cycles(5);
    check_output("glitch_busy_rise", 32'(busy_seen), 32'd1);
    for (int i = 0; i < 60 && busy === 1'b1; i++) wait_cycles(1);
    check_output("glitch_busy_fall", 32'(busy), 32'd0);
    check_output("glitch_fall_time", 32'((cyc - t0) >= 24 && (cyc - t0) <= 32), 32'd1);
    wait_cycles(50);
    check_output("glitch_no_valid", 32'(valid_count - vc), 32'd0);

    // Stop bit forced low, then a clean frame.
    apply_stimulus(8'h3C, 50, 1'b0, 1'b1);
    wait_cycles(10);
    apply_stimulus(8'h81, 50, 1'b1, 1'b1);
    wait_cycles(10);
    drain("drain_stop_err");

    // Back-to-back frames at the transmitter's 51-cycle bit period.
    vc = valid_count;
    apply_stimulus(8'h00, 51, 1'b1, 1'b1);
    apply_stimulus(8'hFF, 51, 1'b1, 1'b1);
    wait_cycles(10);
    drain("drain_back_to_back");
    check_output("b2b_valid_count", 32'(valid_count - vc), 32'd2);

    // Reset in the middle of frame 0x12: that frame must never appear.
    vc = valid_count;
    d = 8'h12;
    drive_bit(1'b0, 50);
    for (int i = 0; i < 3; i++) drive_bit(d[i], 50);
    #3;
    resetn = 1'b0;
    #1;
    check_output("midframe_reset_busy", 32'(busy), 32'd0);
    check_output("midframe_reset_data", 32'(data), 32'd0);
    rxd = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_cycles(400);
    check_output("midframe_no_valid", 32'(valid_count - vc), 32'd0);
    apply_stimulus(8'h5A, 50, 1'b1, 1'b1);
    wait_cycles(10);
    drain("drain_5a");

    // Receiver disabled: the frame is ignored entirely.
    en = 1'b0;
    vc = valid_count;
    busy_seen = 1'b0;
    apply_stimulus(8'h6B, 50, 1'b1, 1'b0);
    wait_cycles(50);
    check_output("disabled_busy", 32'(busy_seen), 32'd0);
    check_output("disabled_no_valid", 32'(valid_count - vc), 32'd0);
    en = 1'b1;
    wait_cycles(5);

    // Break: one all-zero frame with an error, then nothing until line high.
    vc = valid_count;
    e.data = '0;
    e.err = 1'b1;
    e.start_cyc = cyc;
    e.bit_len = 50;
    exp_q.push_back(e);
    drive_bit(1'b0, 1200);
    check_output("break_idle", 32'(busy), 32'd0);
    check_output("break_one_valid", 32'(valid_count - vc), 32'd1);
    rxd = 1'b1;
    wait_cycles(20);
    check_output("break_after_release", 32'(valid_count - vc), 32'd1);
    drain("drain_break");

    // Randomised frames within the tolerated bit-period range.
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      apply_stimulus(d, int'($urandom_range(50, 51)), ok, 1'b1);
      gap = ok ? int'($urandom_range(0, 15)) : int'($urandom_range(3, 15));
      wait_cycles(gap);
    end
    wait_cycles(20);
    drain("drain_random");

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
